// File: rtl/lc_prefetch.sv
// Byte-granular location counter with a one-word instruction prefetch buffer.
// Fetches the word containing lc over req/ack and presents the addressed unit to decode.
module lc_prefetch #(
  parameter int LC_W  = 26,
  parameter int SUB_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      state_fetch,
  input  logic                      destlc,
  input  logic [LC_W-1:0]           ob,
  input  logic                      lcinc,
  input  logic [1:0]                step_mode,
  input  logic                      inval,
  output logic                      fetch_req,
  output logic [LC_W-SUB_W-1:0]     fetch_addr,
  input  logic                      fetch_ack,
  input  logic [(8<<SUB_W)-1:0]     fetch_data,
  output logic [LC_W-1:0]           lc,
  output logic                      unit_valid,
  output logic [(8<<SUB_W)-1:0]     unit_data,
  output logic                      needfetch,
  output logic [LC_W+3:0]           mf_lc
);

  localparam int DATA_W = 8 << SUB_W;
  localparam int TAG_W  = LC_W - SUB_W;

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e              state_q, state_d;
  logic [LC_W-1:0]     lc_q, lc_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic [TAG_W-1:0]    buf_tag_q, buf_tag_d;
  logic                buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]    fetch_addr_q, fetch_addr_d;
  logic                discard_q, discard_d;

  logic [LC_W-1:0]     step;
  logic [SUB_W-1:0]    byte_off, half_off;
  logic [DATA_W-1:0]   byte_shift, half_shift;
  logic                hit;

  assign hit = buf_valid_q && (buf_tag_q == lc_q[LC_W-1:SUB_W]);

  // Unit extraction: lanes are little-endian; halfword mode ignores lc[0].
  assign byte_off   = lc_q[SUB_W-1:0];
  assign half_off   = byte_off & ~SUB_W'(1);
  assign byte_shift = buf_data_q >> {byte_off, 3'b000};
  assign half_shift = buf_data_q >> {half_off, 3'b000};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    unit_data = '0;
    if (hit) begin
      case (step_mode)
        2'd0:    unit_data = DATA_W'(byte_shift[7:0]);
        2'd1:    unit_data = DATA_W'(half_shift[15:0]);
        default: unit_data = buf_data_q;
      endcase
    end
  end

  always_comb begin
    step = '0;
    case (step_mode)
      2'd0:    step = LC_W'(1);
      2'd1:    step = LC_W'(2);
      default: step = LC_W'(1) << SUB_W;
    endcase
  end

  always_comb begin
    lc_d         = lc_q;
    state_d      = state_q;
    buf_data_d   = buf_data_q;
    buf_tag_d    = buf_tag_q;
    buf_valid_d  = buf_valid_q;
    fetch_addr_d = fetch_addr_q;
    discard_d    = discard_q;

    if (state_fetch) begin
      if (destlc)     lc_d = ob;
      else if (lcinc) lc_d = lc_q + step;
    end

    case (state_q)
      S_IDLE: begin
        if (!hit && !inval) begin
          fetch_addr_d = lc_q[LC_W-1:SUB_W];
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (inval) discard_d = 1'b1;
        if (fetch_ack) begin
          // A request is always completed; invalidation only decides whether its data lands.
          if (!discard_q && !inval) begin
            buf_data_d  = fetch_data;
            buf_tag_d   = fetch_addr_q;
            buf_valid_d = 1'b1;
          end
          discard_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (inval) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lc_q         <= '0;
      buf_data_q   <= '0;
      buf_tag_q    <= '0;
      buf_valid_q  <= 1'b0;
      fetch_addr_q <= '0;
      discard_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      lc_q         <= lc_d;
      buf_data_q   <= buf_data_d;
      buf_tag_q    <= buf_tag_d;
      buf_valid_q  <= buf_valid_d;
      fetch_addr_q <= fetch_addr_d;
      discard_q    <= discard_d;
    end
  end

  assign fetch_req  = (state_q == S_REQ);
  assign fetch_addr = fetch_addr_q;
  assign lc         = lc_q;
  assign unit_valid = hit;
  assign needfetch  = !hit;
  assign mf_lc      = {!hit, hit, step_mode, lc_q};

endmodule

// File: tb/tb_lc_prefetch.sv
// Directed self-checking bench for lc_prefetch: fills, unit extraction, LC stepping,
// load priority, wrap, LC moving during a request, invalidation and reset mid-request.
module tb_lc_prefetch;

  localparam int LC_W   = 26;
  localparam int SUB_W  = 2;
  localparam int DATA_W = 8 << SUB_W;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  state_fetch, destlc, lcinc, inval, fetch_ack;
  logic [LC_W-1:0]       ob;
  logic [1:0]            step_mode;
  logic [DATA_W-1:0]     fetch_data;
  logic                  fetch_req, unit_valid, needfetch;
  logic [LC_W-SUB_W-1:0] fetch_addr;
  logic [LC_W-1:0]       lc;
  logic [DATA_W-1:0]     unit_data;
  logic [LC_W+3:0]       mf_lc;

  int checks = 0;
  int errors = 0;

  lc_prefetch #(.LC_W(LC_W), .SUB_W(SUB_W)) dut (
    .clk(clk), .reset(reset), .state_fetch(state_fetch), .destlc(destlc), .ob(ob),
    .lcinc(lcinc), .step_mode(step_mode), .inval(inval), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data), .lc(lc),
    .unit_valid(unit_valid), .unit_data(unit_data), .needfetch(needfetch), .mf_lc(mf_lc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; state_fetch = 0; destlc = 0; lcinc = 0; inval = 0;
    fetch_ack = 0; ob = '0; step_mode = 2'd0; fetch_data = '0;
    #1;
    check("rst_lc",         lc, 0);
    check("rst_fetch_req",  fetch_req, 0);
    check("rst_fetch_addr", fetch_addr, 0);
    check("rst_unit_valid", unit_valid, 0);
    check("rst_unit_data",  unit_data, 0);
    check("rst_needfetch",  needfetch, 1);
    check("rst_mf_lc",      mf_lc, 64'h2000_0000);
    tick();
    reset = 1'b0;

    // First miss after reset: request to word 0, then fill.
    tick();
    check("idle_req",  fetch_req, 1);
    check("idle_addr", fetch_addr, 0);
    fetch_ack = 1; fetch_data = 32'h4433_2211;
    tick();
    fetch_ack = 0;
    check("fill_valid", unit_valid, 1);
    check("fill_byte0", unit_data, 32'h11);
    check("fill_req_low", fetch_req, 0);
    check("fill_mf_lc", mf_lc, 64'h1000_0000);

    // Three byte steps walk to the top lane.
    state_fetch = 1; lcinc = 1; step_mode = 2'd0;
    tick();
    check("byte1", unit_data, 32'h22);
    tick();
    check("byte2", unit_data, 32'h33);
    tick();
    check("byte3_lc", lc, 3);
    check("byte3", unit_data, 32'h44);
    state_fetch = 0;
    tick();
    check("hold_no_strobe", lc, 3);

    // Halfword extraction and stepping out of the word.
    state_fetch = 1; destlc = 1; lcinc = 0; ob = 26'd2; step_mode = 2'd1;
    tick();
    check("half_lc", lc, 2);
    check("half_data", unit_data, 32'h4433);
    destlc = 0; lcinc = 1;
    tick();
    state_fetch = 0; lcinc = 0;
    check("half_step_lc", lc, 4);
    check("half_step_miss", unit_valid, 0);
    check("half_needfetch", needfetch, 1);
    tick();
    check("half_req", fetch_req, 1);
    check("half_addr", fetch_addr, 1);
    fetch_ack = 1; fetch_data = 32'hCAFE_F00D;
    tick();
    fetch_ack = 0;
    check("half_fill", unit_data, 32'hF00D);

    // Load beats step; then wrap from the top of the address space.
    state_fetch = 1; destlc = 1; lcinc = 1; ob = 26'h123; step_mode = 2'd0;
    tick();
    check("load_wins", lc, 26'h123);
    lcinc = 0; ob = 26'h3FF_FFFF;
    tick();
    check("load_top", lc, 26'h3FF_FFFF);
    check("req_0x48", fetch_addr, 26'h48);
    destlc = 0; lcinc = 1; fetch_ack = 1; fetch_data = 32'h0000_0055;
    tick();
    state_fetch = 0; lcinc = 0; fetch_ack = 0;
    check("wrap_lc", lc, 0);
    check("wrap_stale_tag", unit_valid, 0);
    tick();
    check("wrap_req", fetch_req, 1);
    check("wrap_addr", fetch_addr, 0);
    fetch_ack = 1; fetch_data = 32'h4433_2211;
    tick();
    fetch_ack = 0;
    check("wrap_fill", unit_data, 32'h11);

    // Word mode: LC leaves the word while the request is outstanding.
    state_fetch = 1; destlc = 1; ob = 26'd8; step_mode = 2'd2;
    tick();
    state_fetch = 0; destlc = 0;
    tick();
    check("word_req", fetch_req, 1);
    check("word_addr", fetch_addr, 2);
    state_fetch = 1; lcinc = 1;
    tick();
    state_fetch = 0; lcinc = 0;
    check("word_move_lc", lc, 12);
    check("word_addr_stable", fetch_addr, 2);
    check("word_req_held", fetch_req, 1);
    fetch_ack = 1; fetch_data = 32'h1111_2222;
    tick();
    fetch_ack = 0;
    check("word_old_tag_miss", unit_valid, 0);
    check("word_old_tag_data", unit_data, 0);
    check("word_req_gap", fetch_req, 0);
    tick();
    check("word_req2", fetch_req, 1);
    check("word_addr2", fetch_addr, 3);
    fetch_ack = 1; fetch_data = 32'hA5A5_5A5A;
    tick();
    fetch_ack = 0;
    check("word_fill", unit_data, 32'hA5A5_5A5A);

    // inval together with ack: data dropped, request reissued.
    state_fetch = 1; destlc = 1; ob = 26'h10;
    tick();
    state_fetch = 0; destlc = 0;
    tick();
    check("inv_req", fetch_req, 1);
    inval = 1; fetch_ack = 1; fetch_data = 32'hDEAD_BEEF;
    tick();
    inval = 0; fetch_ack = 0;
    check("inv_ack_valid", unit_valid, 0);
    check("inv_ack_data", unit_data, 0);
    check("inv_ack_req", fetch_req, 0);
    tick();
    check("inv_reissue", fetch_req, 1);
    check("inv_reissue_addr", fetch_addr, 4);

    // inval alone in REQ: the later ack is discarded.
    inval = 1;
    tick();
    inval = 0;
    check("inv_keep_req", fetch_req, 1);
    fetch_ack = 1; fetch_data = 32'h1234_5678;
    tick();
    fetch_ack = 0;
    check("discard_valid", unit_valid, 0);
    tick();
    check("discard_reissue", fetch_req, 1);

    // Reset mid-request takes effect without a clock edge.
    state_fetch = 1; destlc = 1; ob = 26'h10;
    reset = 1;
    #1;
    check("rst_mid_req", fetch_req, 0);
    check("rst_mid_lc", lc, 0);
    check("rst_mid_valid", unit_valid, 0);
    state_fetch = 0; destlc = 0;
    tick();
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc_prefetch.md
# lc_prefetch

Parametrised location counter with a one-word instruction prefetch buffer. It is the successor to the fixed 26-bit byte/halfword LC register. It holds a byte-granular program location that the microcode loads or steps on each fetch state, in byte, halfword or word steps. It fetches the containing word over a req/ack port whenever the buffered word does not match. It presents the addressed byte, halfword or word, zero-extended, to the macro-instruction decode path, and exposes LC plus status for the MF source mux.

## Interface
- LC_W, 26, location counter width in bytes-address bits
- SUB_W, 2, sub-word address bits; bytes per word = 2^SUB_W; legal range 1..3
- DATA_W, 8<<SUB_W, fetched word width (derived, not overridable)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- state_fetch  in  1  update strobe; LC changes only in cycles with this high
- destlc  in  1  load LC from ob (qualified by state_fetch)
- ob  in  LC_W  load value
- lcinc  in  1  step LC (qualified by state_fetch)
- step_mode  in  2  0 byte (+1), 1 halfword (+2), 2 word (+2^SUB_W), 3 treated as 2
- inval  in  1  invalidate buffer and any in-flight fetch
- fetch_req  out  1  word fetch request
- fetch_addr  out  LC_W-SUB_W  word address of request
- fetch_ack  in  1  data valid on fetch_data this cycle
- fetch_data  in  DATA_W  fetched word
- lc  out  LC_W  current location counter
- unit_valid  out  1  buffered word matches lc word address
- unit_data  out  DATA_W  addressed unit, zero-extended
- needfetch  out  1  equals !unit_valid
- mf_lc  out  LC_W+4  {needfetch, unit_valid, step_mode, lc} for MF mux

## Operation
- LC update when state_fetch=1:
  - destlc=1: lc <= ob. Load wins over lcinc.
  - else lcinc=1: lc <= lc + step, modulo 2^LC_W, with wrap to 0 and no flag.
  - else: hold.
- No change when state_fetch=0, regardless of destlc/lcinc.
- Buffer:
  - Registers buf_data (DATA_W), buf_tag (LC_W-SUB_W) and buf_valid.
  - unit_valid = buf_valid && buf_tag == lc[LC_W-1:SUB_W], combinational on registered state.
- unit_data, which is zero when unit_valid=0:
  - byte mode: byte lc[SUB_W-1:0] of buf_data.
  - halfword mode: halfword lc[SUB_W-1:1]; lc[0] ignored.
  - word mode: whole buf_data.
  - Byte 0 is buf_data[7:0] (little-endian lanes).
- Fetch FSM, states IDLE and REQ:
  - IDLE: if !unit_valid and !inval, latch fetch_addr <= lc word address, go REQ.
  - REQ:
    - fetch_req=1; fetch_addr stable.
    - On fetch_ack with discard=0: buf_data <= fetch_data, buf_tag <= fetch_addr, buf_valid <= 1, go IDLE.
    - On fetch_ack with discard=1: drop the data, clear discard, go IDLE.
- discard flag: set by inval while in REQ.
- inval:
  - buf_valid <= 0 the same edge.
  - A request already issued is completed and its data discarded.
  - inval in IDLE suppresses a new request that cycle only.
- LC moving to another word while in REQ does not abort the request:
  - The data is installed with the old tag.
  - The mismatch then triggers a fresh request from IDLE.
- fetch_ack while in IDLE is ignored.
- inval and fetch_ack in the same REQ cycle: data discarded, buffer invalid.

## Timing
- Reset values:
  - lc=0, buf_valid=0, buf_tag=0, buf_data=0, discard=0, state IDLE.
  - Outputs: fetch_req=0, fetch_addr=0, unit_valid=0, unit_data=0, needfetch=1, mf_lc={1,0,step_mode,0}.
- Reset asserted mid-request drops the request immediately; no data is installed.
- LC load or step at edge E: new lc, unit_valid and unit_data are visible after E.
- Miss path:
  - needfetch seen in cycle after E; fetch_req rises after E+1.
  - With ack in the first REQ cycle, buffer fills at E+2; unit_valid=1 after E+2.
  - Minimum miss latency is 2 cycles.
- fetch_req stays high until the edge where fetch_ack=1 is sampled. It is low for at least one cycle between requests.
- One request outstanding at most.

## Test plan
- Reset, then stay idle: fetch_req rises with fetch_addr=0. Ack with 0x44332211 -> unit_valid=1; byte mode unit_data=0x11; after three byte steps unit_data=0x44.
- Halfword mode, lc=2, buffer holds 0x44332211 -> unit_data=0x4433. One step -> lc=4, unit_valid=0, fetch_addr=1.
- Same state_fetch cycle with destlc=1, ob=0x123, lcinc=1 -> lc=0x123 (load wins). lc=0x3FFFFFF, byte step -> lc=0, new request to word 0.
- Word mode: issue request, step LC to the next word before ack. Ack installs the old tag, unit_valid stays 0, and a second request to the new word follows.
- inval in the REQ cycle with ack 0xDEADBEEF -> buffer not written, unit_valid=0, request reissued. Assert reset during REQ -> fetch_req=0, lc=0 immediately.
